// File: rtl/axi_lite_video_reg_bridge.sv
// axi_lite_video_reg_bridge: AXI4-Lite slave driving 4-phase strobe/ack coefficient writes and histogram reads
module axi_lite_video_reg_bridge #(
    parameter int NUM_COEF    = 5,
    parameter int TIMEOUT_W   = 26,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [7:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [7:0]  fir_addr_o,
    output logic [31:0] fir_coeff_o,
    output logic        wr_strobe_o,
    input  logic        wr_ack_i,
    output logic        rd_strobe_o,
    input  logic        rd_ack_i,
    input  logic [31:0] hist_bin_i
);
    localparam int IW = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam logic [8:0] COEF_END = 9'(4 * NUM_COEF);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_REL, WR_RESP, RD_REQ, RD_REL, RD_RESP} state_t;

    state_t state, state_n;
    logic [1:0] wr_sync, rd_sync;
    logic wr_ack_s, rd_ack_s;
    logic [TIMEOUT_W-1:0] tcnt, tcnt_n;
    logic [15:0] timeout_cnt, timeout_cnt_n;
    logic last_wr, last_wr_n;
    logic [31:0] shadow [2**IW];
    logic shadow_we;
    logic wr_strobe_n, rd_strobe_n, bvalid_n, rvalid_n;
    logic [1:0] bresp_n, rresp_n;
    logic [31:0] rdata_n, fir_coeff_n;
    logic [7:0] fir_addr_n;
    logic take_wr, take_rd, coef_w, coef_r, timed_out;

    assign wr_ack_s  = wr_sync[1];
    assign rd_ack_s  = rd_sync[1];
    assign take_wr   = s_awvalid & s_wvalid & (!s_arvalid | !last_wr);
    assign take_rd   = s_arvalid & !take_wr;
    assign coef_w    = ({1'b0, s_awaddr} < COEF_END) && (s_awaddr[1:0] == 2'b00);
    assign coef_r    = ({1'b0, s_araddr} < COEF_END) && (s_araddr[1:0] == 2'b00);
    assign timed_out = tcnt == TO_LAST;

    // State, handshake outputs, ack synchronisers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_sync     <= '0;
            rd_sync     <= '0;
            tcnt        <= '0;
            timeout_cnt <= '0;
            last_wr     <= 1'b0;
            wr_strobe_o <= 1'b0;
            rd_strobe_o <= 1'b0;
            s_bvalid    <= 1'b0;
            s_bresp     <= OKAY;
            s_rvalid    <= 1'b0;
            s_rresp     <= OKAY;
            s_rdata     <= '0;
            fir_addr_o  <= '0;
            fir_coeff_o <= '0;
        end else begin
            state       <= state_n;
            wr_sync     <= {wr_sync[0], wr_ack_i};
            rd_sync     <= {rd_sync[0], rd_ack_i};
            tcnt        <= tcnt_n;
            timeout_cnt <= timeout_cnt_n;
            last_wr     <= last_wr_n;
            wr_strobe_o <= wr_strobe_n;
            rd_strobe_o <= rd_strobe_n;
            s_bvalid    <= bvalid_n;
            s_bresp     <= bresp_n;
            s_rvalid    <= rvalid_n;
            s_rresp     <= rresp_n;
            s_rdata     <= rdata_n;
            fir_addr_o  <= fir_addr_n;
            fir_coeff_o <= fir_coeff_n;
        end
    end

    // Local copy of coefficients so COEF reads never touch the pixel domain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IW; i++) shadow[i] <= '0;
        end else if (shadow_we) begin
            shadow[s_awaddr[IW+1:2]] <= s_wdata;
        end
    end

    // Next-state and output decisions; acceptance is gated until both acks are released
    always_comb begin
        state_n       = state;
        last_wr_n     = last_wr;
        timeout_cnt_n = timeout_cnt;
        wr_strobe_n   = wr_strobe_o;
        rd_strobe_n   = rd_strobe_o;
        bvalid_n      = s_bvalid;
        bresp_n       = s_bresp;
        rvalid_n      = s_rvalid;
        rresp_n       = s_rresp;
        rdata_n       = s_rdata;
        fir_addr_n    = fir_addr_o;
        fir_coeff_n   = fir_coeff_o;
        shadow_we     = 1'b0;
        s_awready     = 1'b0;
        s_wready      = 1'b0;
        s_arready     = 1'b0;
        case (state)
            IDLE: if (!rst && !wr_ack_s && !rd_ack_s) begin
                if (take_wr) begin
                    s_awready = 1'b1;
                    s_wready  = 1'b1;
                    last_wr_n = 1'b1;
                    if (coef_w && s_wstrb == 4'hF) begin
                        fir_addr_n  = s_awaddr;
                        fir_coeff_n = s_wdata;
                        shadow_we   = 1'b1;
                        wr_strobe_n = 1'b1;
                        state_n     = WR_REQ;
                    end else begin
                        bvalid_n = 1'b1;
                        bresp_n  = SLVERR;
                        state_n  = WR_RESP;
                    end
                end else if (take_rd) begin
                    s_arready = 1'b1;
                    last_wr_n = 1'b0;
                    if (s_araddr == 8'h40) begin
                        rd_strobe_n = 1'b1;
                        state_n     = RD_REQ;
                    end else begin
                        rvalid_n = 1'b1;
                        state_n  = RD_RESP;
                        rresp_n  = (coef_r || s_araddr == 8'h44) ? OKAY : SLVERR;
                        rdata_n  = coef_r ? shadow[s_araddr[IW+1:2]] :
                                   (s_araddr == 8'h44) ? {16'b0, timeout_cnt} : '0;
                    end
                end
            end
            WR_REQ, WR_REL: begin
                if (state == WR_REQ && wr_ack_s) begin
                    wr_strobe_n = 1'b0;
                    state_n     = WR_REL;
                end else if (state == WR_REL && !wr_ack_s) begin
                    bvalid_n = 1'b1;
                    bresp_n  = OKAY;
                    state_n  = WR_RESP;
                end else if (timed_out) begin
                    wr_strobe_n   = 1'b0;
                    bvalid_n      = 1'b1;
                    bresp_n       = SLVERR;
                    timeout_cnt_n = timeout_cnt + 16'(timeout_cnt != 16'hFFFF);
                    state_n       = WR_RESP;
                end
            end
            RD_REQ, RD_REL: begin
                if (state == RD_REQ && rd_ack_s) begin
                    rdata_n     = hist_bin_i;
                    rd_strobe_n = 1'b0;
                    state_n     = RD_REL;
                end else if (state == RD_REL && !rd_ack_s) begin
                    rvalid_n = 1'b1;
                    rresp_n  = OKAY;
                    state_n  = RD_RESP;
                end else if (timed_out) begin
                    rd_strobe_n   = 1'b0;
                    rvalid_n      = 1'b1;
                    rresp_n       = SLVERR;
                    rdata_n       = '0;
                    timeout_cnt_n = timeout_cnt + 16'(timeout_cnt != 16'hFFFF);
                    state_n       = RD_RESP;
                end
            end
            WR_RESP: if (s_bready) begin
                bvalid_n = 1'b0;
                state_n  = IDLE;
            end
            RD_RESP: if (s_rready) begin
                rvalid_n = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        tcnt_n = (state_n == state && state inside {WR_REQ, WR_REL, RD_REQ, RD_REL}) ?
                 tcnt + TIMEOUT_W'(1) : '0;
    end
endmodule

// File: tb/tb_axi_lite_video_reg_bridge.sv
// tb_axi_lite_video_reg_bridge: randomized directed bench with a spec-level register/handshake model
module tb_axi_lite_video_reg_bridge;
    localparam int N  = 5;
    localparam int TW = 11;
    localparam int TC = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [7:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [7:0]  fir_addr_o;
    logic [31:0] fir_coeff_o;
    logic        wr_strobe_o;
    logic        wr_ack_i = 1'b0;
    logic        rd_strobe_o;
    logic        rd_ack_i = 1'b0;
    logic [31:0] hist_bin_i = '0;

    int asserts = 0;
    int fails = 0;
    int wr_dly = 2;
    int rd_dly = 2;
    bit rd_never = 1'b0;
    logic [31:0] rd_bin = '0;
    logic [31:0] m_shadow [N];
    int m_to = 0;
    int order_q[$];
    logic [7:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    int n;

    axi_lite_video_reg_bridge #(.NUM_COEF(N), .TIMEOUT_W(TW), .TIMEOUT_CYC(TC)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .fir_addr_o(fir_addr_o), .fir_coeff_o(fir_coeff_o), .wr_strobe_o(wr_strobe_o),
        .wr_ack_i(wr_ack_i), .rd_strobe_o(rd_strobe_o), .rd_ack_i(rd_ack_i),
        .hist_bin_i(hist_bin_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_coef(input logic [7:0] a);
        return int'(a) < 4 * N && a[1:0] == 2'b00;
    endfunction

    // Pixel-domain write responder: ack some cycles after strobe, release once strobe drops
    initial forever begin
        @(posedge clk);
        if (wr_strobe_o && !wr_ack_i) begin
            repeat (wr_dly) @(posedge clk);
            #2 wr_ack_i = 1'b1;
            while (wr_strobe_o) @(posedge clk);
            #2 wr_ack_i = 1'b0;
        end
    end

    // Pixel-domain histogram responder
    initial forever begin
        @(posedge clk);
        if (rd_strobe_o && !rd_ack_i && !rd_never) begin
            repeat (rd_dly) @(posedge clk);
            #2 hist_bin_i = rd_bin;
            rd_ack_i = 1'b1;
            while (rd_strobe_o) @(posedge clk);
            #2 rd_ack_i = 1'b0;
        end
    end

    // Coefficient bus must be stable while the strobe is up, and strobes are exclusive
    always @(negedge clk) begin
        if (!rst && wr_strobe_o) begin
            check("fir_addr_stable", 32'(fir_addr_o), 32'(exp_addr));
            check("fir_coeff_stable", fir_coeff_o, exp_data);
            check("strobe_exclusive", 32'(rd_strobe_o), 32'd0);
        end
    end

    // Records the order in which the DUT accepts transactions (1 = write, 0 = read)
    always @(posedge clk) begin
        if (!rst) begin
            if (s_awready && s_awvalid && s_wvalid) order_q.push_back(1);
            if (s_arready && s_arvalid) order_q.push_back(0);
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st, input int bdly);
        int k;
        bit legal;
        logic [1:0] er;
        legal = is_coef(a) && st == 4'hF;
        er = legal ? 2'b00 : 2'b10;
        if (legal) begin
            exp_addr = a;
            exp_data = d;
        end
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        k = 0;
        while (!(s_awready && s_wready) && k < 5000) begin
            @(negedge clk); #1; k++;
        end
        check("aw_accept", 32'(k < 5000), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (legal) m_shadow[int'(a) / 4] = d;
        check("wr_strobe_latency", 32'(wr_strobe_o), 32'(legal));
        k = 0;
        while (!s_bvalid && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check("bvalid_seen", 32'(s_bvalid), 32'd1);
        if (legal) check("b_latency_ge5", 32'(k >= 5), 32'd1);
        check("bresp", 32'(s_bresp), 32'(er));
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
            check("bresp_hold", 32'(s_bresp), 32'(er));
        end
        @(negedge clk); s_bready = 1'b1;
        @(posedge clk); #1 s_bready = 1'b0;
        check("bvalid_clear", 32'(s_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [7:0] a, input int rdly);
        int k;
        bit hs;
        logic [31:0] ed;
        logic [1:0] er;
        hs = a == 8'h40;
        if (hs) begin
            er = rd_never ? 2'b10 : 2'b00;
            ed = rd_never ? 32'd0 : rd_bin;
        end else if (a == 8'h44) begin
            er = 2'b00; ed = 32'(m_to);
        end else if (is_coef(a)) begin
            er = 2'b00; ed = m_shadow[int'(a) / 4];
        end else begin
            er = 2'b10; ed = 32'd0;
        end
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        #1;
        k = 0;
        while (!s_arready && k < 5000) begin
            @(negedge clk); #1; k++;
        end
        check("ar_accept", 32'(k < 5000), 32'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        check("rd_strobe_latency", 32'(rd_strobe_o), 32'(hs));
        k = 0;
        while (!s_rvalid && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check("rvalid_seen", 32'(s_rvalid), 32'd1);
        if (hs && rd_never) begin
            check("timeout_latency", 32'(k >= TC - 1 && k <= TC + 1), 32'd1);
            m_to++;
        end else if (hs) begin
            check("r_latency_ge5", 32'(k >= 5), 32'd1);
        end
        check("rresp", 32'(s_rresp), 32'(er));
        check("rdata", s_rdata, ed);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(s_rvalid), 32'd1);
            check("rdata_hold", s_rdata, ed);
        end
        @(negedge clk); s_rready = 1'b1;
        @(posedge clk); #1 s_rready = 1'b0;
        check("rvalid_clear", 32'(s_rvalid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_shadow[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_strobes", 32'({wr_strobe_o, rd_strobe_o}), 32'd0);
        check("rst_fir", 32'(fir_addr_o) | fir_coeff_o, 32'd0);
        rst = 1'b0;

        axi_write(8'h08, 32'h0000_0102, 4'hF, 0);
        axi_read(8'h08, 0);

        rd_bin = 32'h1234; rd_dly = 1000;
        axi_read(8'h40, 0);
        rd_dly = 2;

        rd_never = 1'b1;
        axi_read(8'h40, 0);
        rd_never = 1'b0;
        axi_read(8'h44, 0);

        axi_read(8'h00, 0);
        order_q.delete();
        fork
            axi_write(8'h04, $urandom, 4'hF, 0);
            axi_read(8'h08, 0);
        join
        fork
            axi_write(8'h0C, $urandom, 4'hF, 0);
            axi_read(8'h10, 0);
        join
        check("order_len", 32'(order_q.size()), 32'd4);
        if (order_q.size() == 4)
            for (int i = 0; i < 4; i++) check("order", 32'(order_q[i]), 32'(i % 2 == 0));

        axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, 5);
        axi_write(8'h80, 32'h1111_2222, 4'hF, 0);
        axi_write(8'h00, 32'h3333_4444, 4'h3, 0);
        axi_read(8'h00, 0);
        axi_read(8'h10, 0);
        axi_read(8'h14, 0);
        axi_read(8'h90, 2);

        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    wr_dly = $urandom_range(0, 6);
                    axi_write(8'(4 * $urandom_range(0, N - 1)), $urandom, 4'hF, $urandom_range(0, 3));
                end
                1: axi_read(8'(4 * $urandom_range(0, N - 1)), $urandom_range(0, 3));
                default: begin
                    rd_bin = $urandom;
                    rd_dly = $urandom_range(0, 20);
                    axi_read(8'h40, $urandom_range(0, 3));
                end
            endcase
        end
        axi_read(8'h44, 0);

        rd_never = 1'b1;
        @(negedge clk);
        s_araddr = 8'h40; s_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_arready && n < 5000) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1 s_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rd_req_strobe", 32'(rd_strobe_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_drops_strobe", 32'(rd_strobe_o), 32'd0);
        check("rst_no_rvalid", 32'(s_rvalid), 32'd0);
        @(negedge clk); rst = 1'b0; rd_never = 1'b0;
        for (int i = 0; i < N; i++) m_shadow[i] = '0;
        m_to = 0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_rvalid", 32'(s_rvalid), 32'd0);
        end
        axi_read(8'h44, 0);
        axi_read(8'h0C, 0);
        axi_write(8'h0C, $urandom, 4'hF, 0);
        axi_read(8'h0C, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
